// File: rtl/dword_if.sv
// dword_if: decode, memory and register-file signals of the LDW/SDW sequencer
interface dword_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
);
    logic              instr_valid;
    logic [5:0]        opcode;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] eff_addr;
    logic              flush;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] rf_rdata;
    logic              stall;
    logic              mem_en;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [REG_AW-1:0] rf_rd_addr;
    logic              rf_wr_en;
    logic [REG_AW-1:0] rf_wr_addr;
    logic [DATA_W-1:0] rf_wr_data;
    logic              busy;
    logic              done;
    logic              exception;
    modport master (
        output instr_valid, opcode, rd, eff_addr, flush, mem_ready, mem_rdata, rf_rdata,
        input  stall, mem_en, mem_we, mem_addr, mem_wdata, rf_rd_addr, rf_wr_en,
               rf_wr_addr, rf_wr_data, busy, done, exception
    );
    modport slave (
        input  instr_valid, opcode, rd, eff_addr, flush, mem_ready, mem_rdata, rf_rdata,
        output stall, mem_en, mem_we, mem_addr, mem_wdata, rf_rd_addr, rf_wr_en,
               rf_wr_addr, rf_wr_data, busy, done, exception
    );
endinterface

// File: rtl/dword_access_seq.sv
// dword_access_seq: splits LDW/SDW into two word accesses on Rd/Rd+1, stalling decode meanwhile
module dword_access_seq #(
    parameter int DATA_W    = 32,
    parameter int REG_AW    = 4,
    parameter int OP_LDW    = 8,
    parameter int OP_SDW    = 9,
    parameter int ADDR_STEP = 4
) (
    input logic    clk,
    input logic    reset,
    dword_if.slave bus_io
);
    typedef enum logic [1:0] {IDLE, FIRST, SECOND} state_t;
    state_t            state_q;
    logic [REG_AW-1:0] rd_q;
    logic [DATA_W-1:0] addr_q;
    logic              store_q;
    logic              exc_q;
    logic              is_dw, bad, accept, act, second, ld_wr;
    logic [REG_AW-1:0] cur_reg;
    assign is_dw   = bus_io.instr_valid && !bus_io.flush &&
                     (bus_io.opcode == 6'(OP_LDW) || bus_io.opcode == 6'(OP_SDW));
    assign bad     = bus_io.rd[0] || (bus_io.eff_addr[1:0] != 2'b00);
    assign accept  = (state_q == IDLE) && is_dw && !bad;
    assign act     = state_q != IDLE;
    assign second  = state_q == SECOND;
    assign cur_reg = rd_q + REG_AW'(second);
    assign ld_wr   = act && !store_q && bus_io.mem_ready;
    // Stall rises in the accepting cycle so decode holds the instruction immediately
    always_comb begin
        bus_io.stall      = act || accept;
        bus_io.mem_en     = act;
        bus_io.mem_we     = act && store_q;
        bus_io.mem_addr   = act ? addr_q + (second ? DATA_W'(ADDR_STEP) : '0) : '0;
        bus_io.mem_wdata  = (act && store_q) ? bus_io.rf_rdata : '0;
        bus_io.rf_rd_addr = act ? cur_reg : '0;
        bus_io.rf_wr_en   = ld_wr;
        bus_io.rf_wr_addr = act ? cur_reg : '0;
        bus_io.rf_wr_data = ld_wr ? bus_io.mem_rdata : '0;
        bus_io.busy       = act;
        bus_io.done       = second && bus_io.mem_ready;
        bus_io.exception  = exc_q;
    end
    // Flush aborts only before the first access retires; a started pair always completes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rd_q    <= '0;
            addr_q  <= '0;
            store_q <= 1'b0;
            exc_q   <= 1'b0;
        end else begin
            exc_q <= (state_q == IDLE) && is_dw && bad;
            case (state_q)
                IDLE: if (accept) begin
                    state_q <= FIRST;
                    rd_q    <= bus_io.rd;
                    addr_q  <= bus_io.eff_addr;
                    store_q <= bus_io.opcode == 6'(OP_SDW);
                end
                FIRST:   state_q <= bus_io.mem_ready ? SECOND : (bus_io.flush ? IDLE : FIRST);
                SECOND:  state_q <= bus_io.mem_ready ? IDLE : SECOND;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dword_access_seq.sv
// tb_dword_access_seq: directed vector table, async-reset sequence and random run against a queue model
module tb_dword_access_seq;
    logic clk, reset;
    int   checks, failures;
    dword_if #(.DATA_W(32), .REG_AW(4)) bus ();
    dword_access_seq dut (.clk(clk), .reset(reset), .bus_io(bus));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    typedef struct {
        logic v; logic [5:0] op; logic [3:0] rd; logic [31:0] a; logic fl, rdy; logic [31:0] rdata, rfd;
        logic stall, en, we; logic [31:0] maddr, wdata; logic [3:0] rfra; logic wen; logic [3:0] wa;
        logic [31:0] wd; logic done, busy, exc;
    } vec_t;
    typedef struct {logic [31:0] addr; logic [3:0] rg; logic we;} acc_t;
    vec_t tbl[$];
    acc_t q[$];
    logic exc_p;
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", n, act, exp);
        end
    endtask
    task automatic drive(input logic v, input logic [5:0] op, input logic [3:0] rd, input logic [31:0] a,
                         input logic fl, input logic rdy, input logic [31:0] rdata, input logic [31:0] rfd);
        bus.instr_valid = v; bus.opcode = op; bus.rd = rd; bus.eff_addr = a;
        bus.flush = fl; bus.mem_ready = rdy; bus.mem_rdata = rdata; bus.rf_rdata = rfd;
    endtask
    initial begin
        checks = 0; failures = 0;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        // LDW R2 @0x100 with immediate ready
        tbl.push_back('{1,8,2,'h100,0,1,0,0, 1,0,0,0,0,0,0,0,0,0,0,0});
        tbl.push_back('{0,0,0,0,0,1,'hAAAA0000,0, 1,1,0,'h100,0,2,1,2,'hAAAA0000,0,1,0});
        tbl.push_back('{0,0,0,0,0,1,'hBBBB0000,0, 1,1,0,'h104,0,3,1,3,'hBBBB0000,1,1,0});
        tbl.push_back('{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,0,0});
        // odd Rd, then misaligned address: one-cycle exception, no access
        tbl.push_back('{1,8,1,'h100,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,0,0});
        tbl.push_back('{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,0,1});
        tbl.push_back('{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,0,0});
        tbl.push_back('{1,8,2,'h102,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,0,0});
        tbl.push_back('{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,0,1});
        tbl.push_back('{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,0,0});
        // R14/R15 with address wrap
        tbl.push_back('{1,8,14,'hFFFFFFFC,0,1,0,0, 1,0,0,0,0,0,0,0,0,0,0,0});
        tbl.push_back('{0,0,0,0,0,1,1,0, 1,1,0,'hFFFFFFFC,0,14,1,14,1,0,1,0});
        tbl.push_back('{0,0,0,0,0,1,2,0, 1,1,0,0,0,15,1,15,2,1,1,0});
        // flush in FIRST aborts
        tbl.push_back('{1,8,6,'h300,0,0,0,0, 1,0,0,0,0,0,0,0,0,0,0,0});
        tbl.push_back('{0,0,0,0,1,0,0,0, 1,1,0,'h300,0,6,0,0,0,0,1,0});
        tbl.push_back('{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,0,0});
        // flush in SECOND is ignored
        tbl.push_back('{1,8,6,'h300,0,0,0,0, 1,0,0,0,0,0,0,0,0,0,0,0});
        tbl.push_back('{0,0,0,0,0,1,5,0, 1,1,0,'h300,0,6,1,6,5,0,1,0});
        tbl.push_back('{0,0,0,0,1,0,0,0, 1,1,0,'h304,0,7,0,0,0,0,1,0});
        tbl.push_back('{0,0,0,0,1,1,6,0, 1,1,0,'h304,0,7,1,7,6,1,1,0});
        tbl.push_back('{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,0,0});
        // flush in IDLE suppresses accept and exception
        tbl.push_back('{1,8,2,'h100,1,0,0,0, 0,0,0,0,0,0,0,0,0,0,0,0});
        tbl.push_back('{1,8,1,'h100,1,0,0,0, 0,0,0,0,0,0,0,0,0,0,0,0});
        tbl.push_back('{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,0,0});
        // SDW R4 @0x200 with two wait cycles per access, instruction held while busy
        tbl.push_back('{1,9,4,'h200,0,0,0,0, 1,0,0,0,0,0,0,0,0,0,0,0});
        tbl.push_back('{1,9,4,'h200,0,0,0,'h11111111, 1,1,1,'h200,'h11111111,4,0,0,0,0,1,0});
        tbl.push_back('{1,9,4,'h200,0,0,0,'h11111111, 1,1,1,'h200,'h11111111,4,0,0,0,0,1,0});
        tbl.push_back('{1,9,4,'h200,0,1,0,'h11111111, 1,1,1,'h200,'h11111111,4,0,0,0,0,1,0});
        tbl.push_back('{0,0,0,0,0,0,0,'h22222222, 1,1,1,'h204,'h22222222,5,0,0,0,0,1,0});
        tbl.push_back('{0,0,0,0,0,0,0,'h22222222, 1,1,1,'h204,'h22222222,5,0,0,0,0,1,0});
        tbl.push_back('{0,0,0,0,0,1,0,'h22222222, 1,1,1,'h204,'h22222222,5,0,0,0,1,1,0});
        tbl.push_back('{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,0,0});
        // other opcodes ignored
        tbl.push_back('{1,3,2,'h100,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,0,0});
        tbl.push_back('{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,0,0});
        repeat (2) @(posedge clk);
        #1;
        chk("reset stall", bus.stall, 0);
        chk("reset busy", bus.busy, 0);
        chk("reset mem_en", bus.mem_en, 0);
        chk("reset exception", bus.exception, 0);
        chk("reset rf_wr_en", bus.rf_wr_en, 0);
        @(negedge clk) reset = 1'b0;
        foreach (tbl[i]) begin
            vec_t t;
            t = tbl[i];
            @(negedge clk);
            drive(t.v, t.op, t.rd, t.a, t.fl, t.rdy, t.rdata, t.rfd);
            #1;
            chk($sformatf("row%0d stall", i), bus.stall, t.stall);
            chk($sformatf("row%0d mem_en", i), bus.mem_en, t.en);
            chk($sformatf("row%0d busy", i), bus.busy, t.busy);
            chk($sformatf("row%0d done", i), bus.done, t.done);
            chk($sformatf("row%0d exception", i), bus.exception, t.exc);
            chk($sformatf("row%0d rf_wr_en", i), bus.rf_wr_en, t.wen);
            if (t.en) begin
                chk($sformatf("row%0d mem_we", i), bus.mem_we, t.we);
                chk($sformatf("row%0d mem_addr", i), bus.mem_addr, t.maddr);
                chk($sformatf("row%0d rf_rd_addr", i), bus.rf_rd_addr, t.rfra);
                if (t.we) chk($sformatf("row%0d mem_wdata", i), bus.mem_wdata, t.wdata);
            end
            if (t.wen) begin
                chk($sformatf("row%0d rf_wr_addr", i), bus.rf_wr_addr, t.wa);
                chk($sformatf("row%0d rf_wr_data", i), bus.rf_wr_data, t.wd);
            end
        end
        // asynchronous reset in the middle of FIRST, then a normal LDW
        @(negedge clk) drive(1, 8, 2, 'h100, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        drive(0, 0, 0, 0, 0, 1, 'h55, 0);
        chk("pre-reset busy", bus.busy, 1);
        chk("pre-reset mem_en", bus.mem_en, 1);
        reset = 1'b1;
        #1;
        chk("async reset busy", bus.busy, 0);
        chk("async reset stall", bus.stall, 0);
        chk("async reset mem_en", bus.mem_en, 0);
        chk("async reset rf_wr_en", bus.rf_wr_en, 0);
        @(negedge clk) reset = 1'b0;
        @(negedge clk) drive(1, 8, 8, 'h40, 0, 1, 0, 0);
        #1 chk("post-reset accept stall", bus.stall, 1);
        @(negedge clk) drive(0, 0, 0, 0, 0, 1, 'h77, 0);
        #1;
        chk("post-reset addr1", bus.mem_addr, 'h40);
        chk("post-reset wa1", bus.rf_wr_addr, 8);
        chk("post-reset wd1", bus.rf_wr_data, 'h77);
        @(negedge clk) drive(0, 0, 0, 0, 0, 1, 'h88, 0);
        #1;
        chk("post-reset addr2", bus.mem_addr, 'h44);
        chk("post-reset wa2", bus.rf_wr_addr, 9);
        chk("post-reset done", bus.done, 1);
        @(negedge clk) drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("post-reset idle busy", bus.busy, 0);
        // random traffic against a queue of outstanding word accesses
        q.delete();
        exc_p = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic v, fl, rdy, dw, ok, e_wen;
            logic [5:0] op;
            logic [3:0] rd;
            logic [31:0] a, rdata, rfd;
            int r;
            @(negedge clk);
            r = $urandom_range(0, 9);
            v = $urandom_range(0, 2) != 0;
            op = r < 4 ? 6'd8 : r < 8 ? 6'd9 : 6'($urandom_range(0, 63));
            rd = 4'($urandom);
            a = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            fl = $urandom_range(0, 7) == 0;
            rdy = 1'($urandom_range(0, 1));
            rdata = $urandom;
            rfd = $urandom;
            drive(v, op, rd, a, fl, rdy, rdata, rfd);
            dw = v && (op == 6'd8 || op == 6'd9) && !fl;
            ok = !rd[0] && a[1:0] == 2'b00;
            #1;
            chk("rnd exception", bus.exception, exc_p);
            if (q.size() != 0) begin
                e_wen = !q[0].we && rdy;
                chk("rnd stall", bus.stall, 1);
                chk("rnd busy", bus.busy, 1);
                chk("rnd mem_en", bus.mem_en, 1);
                chk("rnd mem_we", bus.mem_we, q[0].we);
                chk("rnd mem_addr", bus.mem_addr, q[0].addr);
                chk("rnd rf_rd_addr", bus.rf_rd_addr, q[0].rg);
                chk("rnd rf_wr_en", bus.rf_wr_en, e_wen);
                chk("rnd done", bus.done, rdy && q.size() == 1);
                if (q[0].we) chk("rnd mem_wdata", bus.mem_wdata, rfd);
                if (e_wen) begin
                    chk("rnd rf_wr_addr", bus.rf_wr_addr, q[0].rg);
                    chk("rnd rf_wr_data", bus.rf_wr_data, rdata);
                end
            end else begin
                chk("rnd idle stall", bus.stall, dw && ok);
                chk("rnd idle busy", bus.busy, 0);
                chk("rnd idle mem_en", bus.mem_en, 0);
                chk("rnd idle rf_wr_en", bus.rf_wr_en, 0);
                chk("rnd idle done", bus.done, 0);
            end
            @(posedge clk);
            exc_p = q.size() == 0 && dw && !ok;
            if (q.size() != 0) begin
                if (rdy) void'(q.pop_front());
                else if (fl && q.size() == 2) q.delete();
            end else if (dw && ok) begin
                q.push_back('{a, rd, op == 6'd9});
                q.push_back('{a + 32'd4, rd + 4'd1, op == 6'd9});
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
